led_panel_monitor: RTL and testbench
====================================

LED_PANEL_MONITOR -- requirements
Module: led_panel_monitor

Interface
REQ-001 Parameter: COLS, default 32, number of sclk bits per panel row (legal range 2..64).
REQ-002 Port: clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: red_in / green_in / blue_in  input  1 each  serial colour data from the panel driver.
REQ-005 Port: sclk_in  input  1  shift clock from the driver; a data bit is taken on its rising edge.
REQ-006 Port: latch_in  input  1  row latch strobe; rising edge ends a row.
REQ-007 Port: blank_in  input  1  display blank; high means LEDs off.
REQ-008 Port: aclk_in / arst_in  input  1 each  row-address clock / row-address reset.
REQ-009 Port: rowmax_in  input  3  highest legal row address.
REQ-010 Port: err_clr  input  1  single-cycle pulse that clears the sticky error flags.
REQ-011 Port: row_valid  output  1  one-cycle pulse; a captured row is available.
REQ-012 Port: row_addr  output  3  row address of the captured row.
REQ-013 Port: row_red / row_green / row_blue  output  COLS each  captured row data; bit 0 is the last bit shifted.
REQ-014 Port: frame_done  output  1  one-cycle pulse, coincident with row_valid when row_addr == rowmax_in.
REQ-015 Port: frame_count  output  16  completed frames; wraps from 0xFFFF to 0.
REQ-016 Port: err_overflow / err_short / err_row / err_blank  output  1 each  sticky error flags.

Function
REQ-017 All inputs except reset SHALL be registered once (stage s1) and once more (stage s2); a rising edge is s1 = 1 and s2 = 0; data bits and levels SHALL be taken from s1.
REQ-018 On an sclk edge with bit_cnt < COLS: each colour shift register SHALL shift left with the s1 data bit entering bit 0, and bit_cnt SHALL increment.
REQ-019 On an sclk edge with bit_cnt == COLS: the shift registers SHALL hold, bit_cnt SHALL hold, and err_overflow SHALL set.
REQ-020 row_ctr SHALL be 3 bits; an arst_in level high in s1 SHALL force row_ctr to 0 and takes priority over aclk.
REQ-021 On an aclk edge: if row_ctr == rowmax_in, row_ctr SHALL wrap to 0 and err_row SHALL set; otherwise row_ctr SHALL increment.
REQ-022 On a latch edge with bit_cnt == COLS: row_red/green/blue SHALL load from the shift registers, row_addr SHALL load row_ctr, and row_valid SHALL pulse on the next cycle.
REQ-023 On a latch edge with bit_cnt < COLS: no row outputs SHALL change, row_valid SHALL stay low, and err_short SHALL set.
REQ-024 On a latch edge where blank_in in s1 = 0: err_blank SHALL set; the capture still proceeds per REQ-022/023.
REQ-025 Every latch edge SHALL clear bit_cnt to 0.
REQ-026 Latency: row_valid SHALL be high during the cycle after the 2nd rising clk edge following the edge at which latch_in is first sampled high.
REQ-027 When sclk and latch edges occur in the same cycle: the bit SHALL be shifted and counted first, and the latch SHALL evaluate the updated count and data.
REQ-028 When aclk and latch edges occur in the same cycle: row_addr SHALL take row_ctr before the increment.
REQ-029 frame_done SHALL pulse with row_valid when the captured row_addr == rowmax_in, and frame_count SHALL increment in that same cycle.
REQ-030 err_clr SHALL clear all sticky flags; if an error event occurs in the same cycle, that flag SHALL end set.
REQ-031 Row outputs SHALL hold their last captured values between captures.

Reset
REQ-032 While reset is high, the following SHALL be 0 on the next clk edge: row_valid, frame_done, row_addr, row_red/green/blue, frame_count, all err_* flags, bit_cnt, row_ctr, shift registers, s1, and s2.
REQ-033 Reset asserted mid-row SHALL discard partial data, and the first latch after release SHALL report err_short.

Verification
REQ-034 Rows 0..7: arst pulse, then 32 sclk with red = 1, green = 0, blue alternating 1/0, blank = 1, latch -> row_valid with row_red = 0xFFFFFFFF, row_green = 0, row_blue = 0xAAAAAAAA, row_addr = 0.
REQ-035 rowmax_in = 7, eight rows with aclk between each -> frame_done and frame_count = 1 on row_addr 7, with no error flags set.
REQ-036 33 sclk edges then latch -> err_overflow = 1, and row_valid pulses with the first 32 bits; 31 sclk edges then latch -> err_short = 1 and no row_valid.
REQ-037 rowmax_in = 3, four aclk edges without arst -> row_ctr wraps to 0 and err_row = 1; err_clr -> all flags 0.
REQ-038 Latch sampled with blank_in = 0 -> err_blank = 1; sclk and latch rising in the same cycle on the 32nd bit -> valid capture containing that bit.

Source files
------------

// File: rtl/led_panel_monitor.sv
// LED panel monitor: snoops a serial RGB panel driver, rebuilds each latched row
// and tracks frame completion plus sticky protocol error flags.
module led_panel_monitor #(
    parameter int COLS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            red_in,
    input  logic            green_in,
    input  logic            blue_in,
    input  logic            sclk_in,
    input  logic            latch_in,
    input  logic            blank_in,
    input  logic            aclk_in,
    input  logic            arst_in,
    input  logic [2:0]      rowmax_in,
    input  logic            err_clr,
    output logic            row_valid,
    output logic [2:0]      row_addr,
    output logic [COLS-1:0] row_red,
    output logic [COLS-1:0] row_green,
    output logic [COLS-1:0] row_blue,
    output logic            frame_done,
    output logic [15:0]     frame_count,
    output logic            err_overflow,
    output logic            err_short,
    output logic            err_row,
    output logic            err_blank
);
    localparam int CW = $clog2(COLS + 1);

    typedef struct packed {
        logic       red;
        logic       green;
        logic       blue;
        logic       sclk;
        logic       latch;
        logic       blank;
        logic       aclk;
        logic       arst;
        logic       clr;
        logic [2:0] rowmax;
    } in_t;

    in_t             in_now, s1, s2;
    logic [CW-1:0]   bit_cnt, cnt_nxt;
    logic [COLS-1:0] sr_red, sr_green, sr_blue;
    logic [COLS-1:0] sr_red_nxt, sr_green_nxt, sr_blue_nxt;
    logic [2:0]      row_ctr;
    logic            cap_pend, cap_last;
    logic            sclk_rise, latch_rise, aclk_rise, full, capture;

    assign in_now = {red_in, green_in, blue_in, sclk_in, latch_in, blank_in,
                     aclk_in, arst_in, err_clr, rowmax_in};

    assign sclk_rise  = s1.sclk  & ~s2.sclk;
    assign latch_rise = s1.latch & ~s2.latch;
    assign aclk_rise  = s1.aclk  & ~s2.aclk;
    assign full       = (bit_cnt == CW'(COLS));

    // Shift happens before the latch looks at the row, so a bit and a latch
    // arriving together are captured as one complete row.
    always_comb begin
        sr_red_nxt   = sr_red;
        sr_green_nxt = sr_green;
        sr_blue_nxt  = sr_blue;
        cnt_nxt      = bit_cnt;
        if (sclk_rise && !full) begin
            sr_red_nxt   = {sr_red[COLS-2:0], s1.red};
            sr_green_nxt = {sr_green[COLS-2:0], s1.green};
            sr_blue_nxt  = {sr_blue[COLS-2:0], s1.blue};
            cnt_nxt      = bit_cnt + CW'(1);
        end
    end

    assign capture = latch_rise && (cnt_nxt == CW'(COLS));

    // row_valid is a one-cycle strobe with no back-pressure: row_* are valid
    // whenever it is high and hold until the next capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1           <= '0;
            s2           <= '0;
            sr_red       <= '0;
            sr_green     <= '0;
            sr_blue      <= '0;
            bit_cnt      <= '0;
            row_ctr      <= '0;
            cap_pend     <= 1'b0;
            cap_last     <= 1'b0;
            row_valid    <= 1'b0;
            row_addr     <= '0;
            row_red      <= '0;
            row_green    <= '0;
            row_blue     <= '0;
            frame_done   <= 1'b0;
            frame_count  <= '0;
            err_overflow <= 1'b0;
            err_short    <= 1'b0;
            err_row      <= 1'b0;
            err_blank    <= 1'b0;
        end else begin
            s1       <= in_now;
            s2       <= s1;
            sr_red   <= sr_red_nxt;
            sr_green <= sr_green_nxt;
            sr_blue  <= sr_blue_nxt;
            bit_cnt  <= latch_rise ? '0 : cnt_nxt;

            if (s1.arst)
                row_ctr <= '0;
            else if (aclk_rise)
                row_ctr <= (row_ctr == s1.rowmax) ? 3'd0 : row_ctr + 3'd1;

            cap_pend <= capture;
            if (capture) begin
                row_red   <= sr_red_nxt;
                row_green <= sr_green_nxt;
                row_blue  <= sr_blue_nxt;
                row_addr  <= row_ctr;
                cap_last  <= (row_ctr == s1.rowmax);
            end

            row_valid  <= cap_pend;
            frame_done <= cap_pend & cap_last;
            if (cap_pend && cap_last)
                frame_count <= frame_count + 16'd1;

            err_overflow <= (err_overflow & ~s1.clr) | (sclk_rise & full);
            err_short    <= (err_short & ~s1.clr) | (latch_rise & ~capture);
            err_row      <= (err_row & ~s1.clr)
                          | (aclk_rise & ~s1.arst & (row_ctr == s1.rowmax));
            err_blank    <= (err_blank & ~s1.clr) | (latch_rise & ~s1.blank);
        end
    end
endmodule

// File: tb/tb_led_panel_monitor.sv
// Directed bench for led_panel_monitor: rows, frames, overflow/short/row/blank
// errors, same-cycle edge ordering, mid-row reset and capture latency.
module tb_led_panel_monitor;
    localparam int COLS = 32;
    localparam int W    = 3 + 3*COLS + 1 + 16;

    logic            clk, reset;
    logic            red_in, green_in, blue_in, sclk_in, latch_in, blank_in;
    logic            aclk_in, arst_in, err_clr;
    logic [2:0]      rowmax_in;
    logic            row_valid, frame_done;
    logic [2:0]      row_addr;
    logic [COLS-1:0] row_red, row_green, row_blue;
    logic [15:0]     frame_count;
    logic            err_overflow, err_short, err_row, err_blank;

    int              n_vec = 0;
    int              n_err = 0;
    logic [W-1:0]    exp_q[$];
    logic [W-1:0]    mon_exp;

    led_panel_monitor #(.COLS(COLS)) dut (
        .clk(clk), .reset(reset),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .sclk_in(sclk_in), .latch_in(latch_in), .blank_in(blank_in),
        .aclk_in(aclk_in), .arst_in(arst_in), .rowmax_in(rowmax_in),
        .err_clr(err_clr),
        .row_valid(row_valid), .row_addr(row_addr),
        .row_red(row_red), .row_green(row_green), .row_blue(row_blue),
        .frame_done(frame_done), .frame_count(frame_count),
        .err_overflow(err_overflow), .err_short(err_short),
        .err_row(err_row), .err_blank(err_blank)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] row_vec(input logic [2:0] a, input logic [COLS-1:0] r,
                                             input logic [COLS-1:0] g, input logic [COLS-1:0] b,
                                             input logic fd, input logic [15:0] fc);
        return {a, r, g, b, fd, fc};
    endfunction

    // driver tasks
    task automatic step();
        @(negedge clk);
    endtask

    task automatic sclk_bit(input logic r, input logic g, input logic b);
        red_in = r; green_in = g; blue_in = b; sclk_in = 1'b1;
        step();
        sclk_in = 1'b0;
        step();
    endtask

    task automatic shift_row(input logic [COLS-1:0] r, input logic [COLS-1:0] g,
                             input logic [COLS-1:0] b, input int n);
        for (int i = 0; i < n; i++)
            sclk_bit(r[COLS-1-i], g[COLS-1-i], b[COLS-1-i]);
    endtask

    task automatic latch_row();
        latch_in = 1'b1;
        step();
        latch_in = 1'b0;
        repeat (4) step();
    endtask

    task automatic pulse_aclk();
        aclk_in = 1'b1; step(); aclk_in = 1'b0; step();
    endtask

    task automatic pulse_arst();
        arst_in = 1'b1; step(); arst_in = 1'b0; step();
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1; step(); err_clr = 1'b0; step();
    endtask

    task automatic check_flags(input string tag, input logic [3:0] exp);
        check(tag, W'({err_overflow, err_short, err_row, err_blank}), W'(exp));
    endtask

    // scoreboard: every row_valid must match the head of exp_q
    always @(negedge clk) begin
        if (row_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("row_unexpected", W'(row_valid), '0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("row", {row_addr, row_red, row_green, row_blue, frame_done, frame_count},
                      mon_exp);
            end
        end
    end

    initial begin
        reset = 1'b1;
        red_in = 0; green_in = 0; blue_in = 0; sclk_in = 0; latch_in = 0;
        blank_in = 1; aclk_in = 0; arst_in = 0; err_clr = 0; rowmax_in = 3'd7;
        repeat (3) step();
        check("rst_valid", W'(row_valid), '0);
        check("rst_rows", {row_addr, row_red, row_green, row_blue, frame_done, frame_count}, '0);
        check_flags("rst_flags", 4'b0000);
        reset = 1'b0;
        step();

        // eight rows of one frame
        pulse_arst();
        for (int r = 0; r < 8; r++) begin
            shift_row(32'hFFFFFFFF, 32'h0, 32'hAAAAAAAA, 32);
            exp_q.push_back(row_vec(3'(r), 32'hFFFFFFFF, 32'h0, 32'hAAAAAAAA,
                                    (r == 7), (r == 7) ? 16'd1 : 16'd0));
            latch_row();
            if (r < 7) pulse_aclk();
        end
        check_flags("frame_flags", 4'b0000);

        // 33 bits: 33rd (all ones) is dropped
        pulse_arst();
        for (int i = 0; i < 33; i++)
            sclk_bit((i < 16) || (i == 32), (i % 2 == 1) || (i == 32), (i < 8) || (i == 32));
        exp_q.push_back(row_vec(3'd0, 32'hFFFF0000, 32'h55555555, 32'hFF000000, 1'b0, 16'd1));
        latch_row();
        check_flags("ovf_flags", 4'b1000);

        // 31 bits: short row, outputs hold
        shift_row(32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 31);
        latch_row();
        check_flags("short_flags", 4'b1100);
        check("hold_red", W'(row_red), W'(32'hFFFF0000));
        pulse_clr();
        check_flags("clr_flags", 4'b0000);

        // row counter wrap at rowmax = 3
        rowmax_in = 3'd3;
        step();
        pulse_arst();
        repeat (3) pulse_aclk();
        check_flags("row3_flags", 4'b0000);
        shift_row(32'hDEADBEEF, 32'h0F0F0F0F, 32'h13579BDF, 32);
        exp_q.push_back(row_vec(3'd3, 32'hDEADBEEF, 32'h0F0F0F0F, 32'h13579BDF, 1'b1, 16'd2));
        latch_row();
        pulse_aclk();
        check_flags("wrap_flags", 4'b0010);
        shift_row(32'h00000001, 32'h80000000, 32'h7FFFFFFE, 32);
        exp_q.push_back(row_vec(3'd0, 32'h00000001, 32'h80000000, 32'h7FFFFFFE, 1'b0, 16'd2));
        latch_row();
        pulse_clr();
        check_flags("clr2_flags", 4'b0000);

        // latch while not blanked
        blank_in = 1'b0;
        shift_row(32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF, 32);
        exp_q.push_back(row_vec(3'd0, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF, 1'b0, 16'd2));
        latch_row();
        blank_in = 1'b1;
        check_flags("blank_flags", 4'b0001);
        pulse_clr();

        // sclk and latch together on the 32nd bit
        shift_row(32'h0, 32'hFFFFFFFF, 32'h0, 31);
        exp_q.push_back(row_vec(3'd0, 32'h00000001, 32'hFFFFFFFE, 32'h00000001, 1'b0, 16'd2));
        red_in = 1'b1; green_in = 1'b0; blue_in = 1'b1; sclk_in = 1'b1; latch_in = 1'b1;
        step();
        sclk_in = 1'b0; latch_in = 1'b0;
        repeat (4) step();
        check_flags("same_flags", 4'b0000);

        // aclk and latch together: address before increment
        shift_row(32'h11111111, 32'h22222222, 32'h44444444, 32);
        exp_q.push_back(row_vec(3'd0, 32'h11111111, 32'h22222222, 32'h44444444, 1'b0, 16'd2));
        aclk_in = 1'b1; latch_in = 1'b1;
        step();
        aclk_in = 1'b0; latch_in = 1'b0;
        repeat (4) step();
        shift_row(32'h88888888, 32'h77777777, 32'h66666666, 32);
        exp_q.push_back(row_vec(3'd1, 32'h88888888, 32'h77777777, 32'h66666666, 1'b0, 16'd2));
        latch_row();

        // reset mid-row discards the partial bits
        shift_row(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 10);
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
        check("rst2_rows", {row_addr, row_red, row_green, row_blue, frame_done, frame_count}, '0);
        shift_row(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 25);
        latch_row();
        check_flags("rst_short", 4'b0100);

        // latency: row_valid in the third cycle after latch is first sampled
        shift_row(32'hA5A5A5A5, 32'h5A5A5A5A, 32'h3C3C3C3C, 32);
        exp_q.push_back(row_vec(3'd0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h3C3C3C3C, 1'b0, 16'd0));
        latch_in = 1'b1;
        step();
        latch_in = 1'b0;
        check("lat_n1", W'(row_valid), W'(1'b0));
        step();
        check("lat_n2", W'(row_valid), W'(1'b0));
        step();
        check("lat_n3", W'(row_valid), W'(1'b1));
        repeat (3) step();

        check("queue_empty", W'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
